fir_decim_out: RTL and testbench

- Output stage directly downstream of the 16-tap FIR filter.
- Consumes the full-precision 2*WIDTH-bit y[n] produced every clock.
- Discards the pipeline-fill transient after reset, then decimates by DECIM.
- Rounds and saturates each kept sample to WIDTH-bit Q1.15 and delivers it over a valid/ready interface through a small FIFO, with sticky saturation and overflow flags.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_out_fifo.sv | 65 ++++++
 rtl/fir_decim_out.sv | 135 +++++++++++++
 tb/tb_fir_decim_out.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_pkg : Q-format constants shared by the FIR filter and its output |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fir_pkg;

   localparam int DEFAULT_WIDTH = 16;

   // Q1.15 output limits and the rounding step for a Q2.30 accumulator
   localparam logic [DEFAULT_WIDTH-1:0] OUT_MAX     = 16'h7FFF;
   localparam logic [DEFAULT_WIDTH-1:0] OUT_MIN     = 16'h8000;
   localparam int                       ROUND_CONST = 1 << (DEFAULT_WIDTH - 2);
   localparam int                       SHIFT       = DEFAULT_WIDTH - 1;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_out_fifo : synchronous first-word-fall-through FIFO              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fir_out_fifo
   import fir_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_push;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_pop   = i_pop && !o_empty;
   // A full FIFO still takes a push when the head leaves on the same edge
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/fir_decim_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_decim_out : skip, decimate, round/saturate and buffer FIR output |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fir_decim_out
   import fir_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DECIM = 4,
   parameter int SKIP  = 16,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2*WIDTH-1:0] i_signal,
   input  logic               i_valid,
   input  logic               i_clr,
   input  logic               i_ready,
   output logic [WIDTH-1:0]   o_signal,
   output logic               o_valid,
   output logic               o_sat,
   output logic               o_overflow
);

   localparam int SW = clog2_min1(SKIP + 1);
   localparam int PW = clog2_min1(DECIM);
   localparam int XW = 2*WIDTH + 1;

   localparam logic signed [XW-1:0] c_round   = {{(WIDTH+2){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
   localparam logic signed [XW-1:0] c_hi      = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0] c_lo      = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]     c_out_max = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]     c_out_min = {1'b1, {(WIDTH-1){1'b0}}};

   logic [SW-1:0]        r_skip_cnt;
   logic [PW-1:0]        r_phase;
   logic                 r_s1_valid;
   logic [WIDTH-1:0]     r_s1_data;
   logic                 r_sat;
   logic                 r_overflow;

   logic                 w_skip_done;
   logic                 w_keep;
   logic signed [XW-1:0] w_sum;
   logic signed [XW-1:0] w_shr;
   logic                 w_sat_hi;
   logic                 w_sat_lo;
   logic [WIDTH-1:0]     w_rounded;
   logic                 w_sat_evt;
   logic                 w_ovf_evt;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;

   assign w_skip_done = (r_skip_cnt == SW'(SKIP));
   assign w_keep      = i_valid && w_skip_done && (r_phase == '0);

   // Round half up: add half an output LSB, then drop the fractional bits
   assign w_sum    = $signed({i_signal[2*WIDTH-1], i_signal}) + c_round;
   assign w_shr    = w_sum >>> (WIDTH - 1);
   assign w_sat_hi = (w_shr > c_hi);
   assign w_sat_lo = (w_shr < c_lo);

   always_comb begin
      w_rounded = w_shr[WIDTH-1:0];
      if (w_sat_hi) begin
         w_rounded = c_out_max;
      end else if (w_sat_lo) begin
         w_rounded = c_out_min;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skip_cnt <= '0;
         r_phase    <= '0;
      end else if (i_valid) begin
         if (!w_skip_done) begin
            r_skip_cnt <= r_skip_cnt + SW'(1);
         end else if (r_phase == PW'(DECIM - 1)) begin
            r_phase <= '0;
         end else begin
            r_phase <= r_phase + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_s1_valid <= w_keep;
         if (w_keep) begin
            r_s1_data <= w_rounded;
         end
      end
   end

   assign w_sat_evt = w_keep && (w_sat_hi || w_sat_lo);
   assign w_pop     = !w_empty && i_ready;
   assign w_ovf_evt = r_s1_valid && w_full && !w_pop;

   // A set event on the same edge as a clear keeps the flag raised
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat      <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_sat      <= (r_sat && !i_clr) || w_sat_evt;
         r_overflow <= (r_overflow && !i_clr) || w_ovf_evt;
      end
   end

   fir_out_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_s1_valid),
      .i_data  (r_s1_data),
      .i_pop   (w_pop),
      .o_data  (o_signal),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_valid    = !w_empty;
   assign o_sat      = r_sat;
   assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fir_decim_out : directed bench for the FIR decimating output stage|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fir_decim_out;
   import fir_pkg::*;

   typedef struct {
      logic [31:0] sig;
      logic [15:0] exp;
      logic        exp_sat;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] i_signal = '0;
   logic        i_valid  = 1'b0;
   logic        i_clr    = 1'b0;
   logic        i_ready  = 1'b1;
   logic [15:0] o_signal;
   logic        o_valid;
   logic        o_sat;
   logic        o_overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fir_decim_out #(
      .WIDTH (16),
      .DECIM (4),
      .SKIP  (16),
      .DEPTH (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_signal   (i_signal),
      .i_valid    (i_valid),
      .i_clr      (i_clr),
      .i_ready    (i_ready),
      .o_signal   (o_signal),
      .o_valid    (o_valid),
      .o_sat      (o_sat),
      .o_overflow (o_overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic [31:0] s);
      i_valid  = v;
      i_signal = s;
      step();
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs [8];
      vecs[0] = '{32'(ROUND_CONST), 16'h0001, 1'b0};
      vecs[1] = '{32'h0000_3FFF,    16'h0000, 1'b0};
      vecs[2] = '{32'hFFFF_C000,    16'h0000, 1'b0};
      vecs[3] = '{32'hFFFF_BFFF,    16'hFFFF, 1'b0};
      vecs[4] = '{32'h3FFF_8000,    OUT_MAX,  1'b0};
      vecs[5] = '{32'h4000_0000,    OUT_MAX,  1'b1};
      vecs[6] = '{32'hBFFF_0000,    OUT_MIN,  1'b1};
      vecs[7] = '{32'h8000_0000,    OUT_MIN,  1'b1};

      // Reset with arbitrary input activity
      #1 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, $urandom);
      end
      check("reset_valid", o_valid, 0);
      check("reset_signal", o_signal, 0);
      check("reset_sat", o_sat, 0);
      check("reset_ovf", o_overflow, 0);
      #2 rst_n = 1'b1;

      // Skip 16 beats, then keep every 4th
      i_ready = 1'b1;
      for (int c = 0; c < 28; c++) begin
         beat(1'b1, 32'(c) << SHIFT);
         check($sformatf("skip_valid_%0d", c), o_valid, (c == 17 || c == 21 || c == 25));
         if (c == 17 || c == 21 || c == 25) begin
            check($sformatf("skip_data_%0d", c), o_signal, 32'(c - 1));
         end
      end

      // Rounding and saturation vectors, each as a kept beat
      for (int v = 0; v < 8; v++) begin
         beat(1'b1, vecs[v].sig);
         check($sformatf("vec%0d_pre_valid", v), o_valid, 0);
         beat(1'b1, 32'h0);
         check($sformatf("vec%0d_valid", v), o_valid, 1);
         check($sformatf("vec%0d_data", v), o_signal, vecs[v].exp);
         check($sformatf("vec%0d_sat", v), o_sat, vecs[v].exp_sat);
         beat(1'b1, 32'h0);
         check($sformatf("vec%0d_one_wide", v), o_valid, 0);
         beat(1'b1, 32'h0);
      end

      // Clear racing a saturation event, then clear alone
      i_clr = 1'b1;
      beat(1'b1, 32'h7FFF_FFFF);
      i_clr = 1'b0;
      beat(1'b1, 32'h0);
      check("clr_race_sat", o_sat, 1);
      check("clr_race_data", o_signal, OUT_MAX);
      i_clr = 1'b1;
      beat(1'b1, 32'h0);
      i_clr = 1'b0;
      check("clr_alone_sat", o_sat, 0);
      beat(1'b1, 32'h0);

      // Backpressure: A, B stored, C dropped
      i_ready = 1'b0;
      beat(1'b1, 32'h0001_0000);
      beat(1'b1, 32'h0);
      check("bp_a_valid", o_valid, 1);
      check("bp_a_head", o_signal, 16'h0002);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0001_8000);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0);
      check("bp_a_stable", o_signal, 16'h0002);
      check("bp_no_ovf_yet", o_overflow, 0);
      beat(1'b1, 32'h0002_0000);
      beat(1'b1, 32'h0);
      check("bp_ovf", o_overflow, 1);
      check("bp_head_after_drop", o_signal, 16'h0002);
      check("bp_valid_held", o_valid, 1);
      i_ready = 1'b1;
      beat(1'b1, 32'h0);
      check("bp_b_valid", o_valid, 1);
      check("bp_b_data", o_signal, 16'h0003);
      check("bp_ovf_sticky", o_overflow, 1);
      beat(1'b1, 32'h0);
      check("bp_drained", o_valid, 0);

      // Push and pop on the same edge while full
      i_clr = 1'b1;
      beat(1'b0, 32'h0);
      i_clr = 1'b0;
      check("ovf_cleared", o_overflow, 0);
      i_ready = 1'b0;
      beat(1'b1, 32'h0002_8000);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0003_0000);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0003_8000);
      i_ready = 1'b1;
      beat(1'b1, 32'h0);
      check("full_pp_ovf", o_overflow, 0);
      check("full_pp_e", o_signal, 16'h0006);
      beat(1'b1, 32'h0);
      check("full_pp_f", o_signal, 16'h0007);
      check("full_pp_f_valid", o_valid, 1);
      beat(1'b1, 32'h0);
      check("full_pp_drained", o_valid, 0);

      // Asynchronous reset while two entries are queued
      i_ready = 1'b0;
      beat(1'b1, 32'h0004_0000);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0);
      beat(1'b1, 32'h0004_8000);
      beat(1'b1, 32'h0);
      check("mid_pre_valid", o_valid, 1);
      check("mid_pre_data", o_signal, 16'h0008);
      #2 rst_n = 1'b0;
      #1;
      check("mid_async_valid", o_valid, 0);
      check("mid_async_signal", o_signal, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      check("mid_after_sat", o_sat, 0);
      i_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         beat(1'b1, 32'h0005_0000);
         check($sformatf("reskip_valid_%0d", c), o_valid, (c == 17));
         if (c == 17) begin
            check("reskip_data", o_signal, 16'h000A);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
